// File: rtl/motor_pkg.sv
// Shared types and constants for the motor command path: FSM encoding,
// command width, lane count and the default throttle ceiling.
package motor_pkg;

    localparam int CMD_W       = 10;
    localparam int NUM_MOTORS  = 4;
    localparam int MAX_CMD_DEF = 1000;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_e;

    typedef logic [CMD_W-1:0] cmd_t;

endpackage

// File: rtl/frame_timer.sv
// Free-running frame counter producing a one-cycle strobe every FRAME_CYCLES clocks.
// Not phase-locked to anything; reusable by any frame-rate logic.
module frame_timer #(
    parameter int FRAME_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_tick
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign frame_tick = (cnt_q == LAST);
    assign cnt_d      = frame_tick ? '0 : cnt_q + 1'b1;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/motor_arm_ramp.sv
// Command stage for four PWM generators: latches clamped throttle targets, gates
// them through an arming FSM with zero-throttle hold, and slew-limits once per frame.
module motor_arm_ramp
    import motor_pkg::*;
#(
    parameter int FRAME_CYCLES   = 1000000,
    parameter int RAMP_STEP      = 8,
    parameter int MAX_CMD        = MAX_CMD_DEF,
    parameter int ARM_FRAMES     = 50,
    parameter int TIMEOUT_FRAMES = 25
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    input  logic [NUM_MOTORS*CMD_W-1:0] throttle_in,
    input  logic                        arm_req,
    input  logic                        disarm_req,
    output logic [CMD_W-1:0]            control_0,
    output logic [CMD_W-1:0]            control_1,
    output logic [CMD_W-1:0]            control_2,
    output logic [CMD_W-1:0]            control_3,
    output logic                        armed,
    output logic [1:0]                  state,
    output logic                        frame_tick
);

    localparam int AW = $clog2(ARM_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [AW-1:0]           ARM_LAST = AW'(ARM_FRAMES);
    localparam logic [TW-1:0]           TMO_MAX  = TW'(TIMEOUT_FRAMES);
    localparam cmd_t                    MAX_C    = CMD_W'(MAX_CMD);
    localparam cmd_t                    STEP_C   = CMD_W'(RAMP_STEP);
    localparam logic signed [CMD_W:0]   STEP_S   = (CMD_W+1)'(RAMP_STEP);

    state_e  state_q, state_d;
    logic    armed_q;
    logic [AW-1:0] arm_cnt_q, arm_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [NUM_MOTORS-1:0][CMD_W-1:0] tgt_q, tgt_d, ctrl_q, ctrl_d;

    logic zero_out, ramp_en, fs_mode, timeout_trip;
    logic tgt_all_zero, out_all_zero;

    frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick)
    );

    // A fresh command always restarts the loss-of-command window, even on a tick.
    assign tmo_d        = cmd_valid ? '0 :
                          (frame_tick && tmo_q != TMO_MAX) ? tmo_q + 1'b1 : tmo_q;
    assign timeout_trip = (tmo_d == TMO_MAX);
    assign tgt_all_zero = (tgt_q == '0);
    assign out_all_zero = (ctrl_q == '0);

    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_lane
        cmd_t                  raw, eff, ramp;
        logic signed [CMD_W:0] diff;

        assign raw      = throttle_in[g*CMD_W +: CMD_W];
        assign tgt_d[g] = cmd_valid ? ((raw > MAX_C) ? MAX_C : raw) : tgt_q[g];
        assign eff      = fs_mode ? '0 : tgt_q[g];
        assign diff     = $signed({1'b0, eff}) - $signed({1'b0, ctrl_q[g]});

        // Within one step of the target the output snaps to it, so it never overshoots.
        always_comb begin
            if (diff > STEP_S)       ramp = ctrl_q[g] + STEP_C;
            else if (diff < -STEP_S) ramp = ctrl_q[g] - STEP_C;
            else                     ramp = eff;
        end

        assign ctrl_d[g] = zero_out ? '0 : (ramp_en ? ramp : ctrl_q[g]);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        zero_out  = 1'b0;
        ramp_en   = 1'b0;
        fs_mode   = 1'b0;
        case (state_q)
            ST_DISARMED: begin
                zero_out = 1'b1;
                if (arm_req && tgt_all_zero) begin
                    state_d   = ST_ARMING;
                    arm_cnt_d = '0;
                end
            end
            ST_ARMING: begin
                zero_out = 1'b1;
                if (!tgt_all_zero || disarm_req) begin
                    state_d = ST_DISARMED;
                end else if (frame_tick) begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                    if (arm_cnt_d == ARM_LAST) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (disarm_req) begin
                    state_d  = ST_DISARMED;
                    zero_out = 1'b1;
                end else if (timeout_trip) begin
                    state_d = ST_FAILSAFE;
                    fs_mode = 1'b1;
                    ramp_en = frame_tick;
                end else begin
                    ramp_en = frame_tick;
                end
            end
            ST_FAILSAFE: begin
                fs_mode = 1'b1;
                if (disarm_req) begin
                    state_d  = ST_DISARMED;
                    zero_out = 1'b1;
                end else if (out_all_zero) begin
                    state_d = ST_DISARMED;
                end else begin
                    ramp_en = frame_tick;
                end
            end
            default: state_d = ST_DISARMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_DISARMED;
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
            tmo_q     <= '0;
            tgt_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= (state_d == ST_ARMED);
            arm_cnt_q <= arm_cnt_d;
            tmo_q     <= tmo_d;
            tgt_q     <= tgt_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign control_0 = ctrl_q[0];
    assign control_1 = ctrl_q[1];
    assign control_2 = ctrl_q[2];
    assign control_3 = ctrl_q[3];
    assign armed     = armed_q;
    assign state     = state_q;

endmodule

// File: tb/tb_motor_arm_ramp.sv
// Scenario-driven bench for motor_arm_ramp with a behavioural reference model
// and a randomized phase checked against that model every cycle.
module tb_motor_arm_ramp;

    localparam int FC   = 10;
    localparam int AF   = 3;
    localparam int TO   = 4;
    localparam int RS   = 8;
    localparam int MAXC = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        arm_req = 1'b0;
    logic        disarm_req = 1'b0;
    logic [39:0] throttle_in = '0;
    logic [9:0]  control_0, control_1, control_2, control_3;
    logic        armed;
    logic [1:0]  state;
    logic        frame_tick;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 waiting for arm, 2 flying, 3 failsafe.
    int m_state, m_fcnt, m_tmo, m_arm;
    int m_out[4];
    int m_tgt[4];
    bit m_tick;

    always #5 clk = ~clk;

    motor_arm_ramp #(
        .FRAME_CYCLES(FC), .RAMP_STEP(RS), .MAX_CMD(MAXC),
        .ARM_FRAMES(AF), .TIMEOUT_FRAMES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .throttle_in(throttle_in),
        .arm_req(arm_req), .disarm_req(disarm_req),
        .control_0(control_0), .control_1(control_1),
        .control_2(control_2), .control_3(control_3),
        .armed(armed), .state(state), .frame_tick(frame_tick)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] pack4(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic int ramp_to(input int o, input int t);
        if (t > o + RS) return o + RS;
        if (t < o - RS) return o - RS;
        return t;
    endfunction

    task automatic model_reset();
        m_state = 0; m_fcnt = 0; m_tmo = 0; m_arm = 0; m_tick = 0;
        for (int i = 0; i < 4; i++) begin m_out[i] = 0; m_tgt[i] = 0; end
    endtask

    task automatic model_update();
        bit tick;
        bit tgt_zero;
        bit out_zero;
        int tmo_n;
        int tgt_n[4];
        tick = (m_fcnt == FC - 1);
        tmo_n = cmd_valid ? 0 : ((tick && m_tmo < TO) ? m_tmo + 1 : m_tmo);
        tgt_zero = 1; out_zero = 1;
        for (int i = 0; i < 4; i++) begin
            if (m_tgt[i] != 0) tgt_zero = 0;
            if (m_out[i] != 0) out_zero = 0;
            tgt_n[i] = m_tgt[i];
            if (cmd_valid) begin
                tgt_n[i] = int'(throttle_in[10*i +: 10]);
                if (tgt_n[i] > MAXC) tgt_n[i] = MAXC;
            end
        end
        case (m_state)
            0: if (arm_req && tgt_zero) begin m_state = 1; m_arm = 0; end
            1: begin
                if (!tgt_zero || disarm_req) m_state = 0;
                else if (tick) begin
                    m_arm++;
                    if (m_arm == AF) m_state = 2;
                end
            end
            2: begin
                if (disarm_req) begin
                    m_state = 0;
                    for (int i = 0; i < 4; i++) m_out[i] = 0;
                end else if (tmo_n == TO) begin
                    m_state = 3;
                    if (tick) for (int i = 0; i < 4; i++) m_out[i] = ramp_to(m_out[i], 0);
                end else if (tick) begin
                    for (int i = 0; i < 4; i++) m_out[i] = ramp_to(m_out[i], m_tgt[i]);
                end
            end
            default: begin
                if (disarm_req) begin
                    m_state = 0;
                    for (int i = 0; i < 4; i++) m_out[i] = 0;
                end else if (out_zero) m_state = 0;
                else if (tick) for (int i = 0; i < 4; i++) m_out[i] = ramp_to(m_out[i], 0);
            end
        endcase
        m_tmo  = tmo_n;
        for (int i = 0; i < 4; i++) m_tgt[i] = tgt_n[i];
        m_fcnt = tick ? 0 : m_fcnt + 1;
        m_tick = tick;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic send_cmd(input logic [39:0] v);
        throttle_in = v; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm_req = 1'b1; step(); arm_req = 1'b0;
    endtask

    task automatic pulse_disarm();
        disarm_req = 1'b1; step(); disarm_req = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        while (seen < n) begin
            step();
            if (m_tick) seen++;
        end
    endtask

    // Leaves the bench one cycle before a frame tick.
    task automatic to_tick_edge();
        while (m_fcnt != FC - 1) step();
    endtask

    task automatic arm_up();
        send_cmd('0);
        pulse_arm();
        wait_ticks(AF);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        n_vec++;
        if ({control_0, control_1, control_2, control_3} !== '0 || state !== 2'd0 ||
            armed !== 1'b0 || frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: ctrl=%0d/%0d/%0d/%0d state=%0d armed=%0b tick=%0b, want all 0",
                     control_0, control_1, control_2, control_3, state, armed, frame_tick);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_arm();
        send_cmd('0);
        pulse_arm();
        n_vec++;
        if (state !== 2'd1 || armed !== 1'b0) begin
            n_err++; $display("FAIL arm_enter: state=%0d armed=%0b, want 1/0", state, armed);
        end
        wait_ticks(AF - 1);
        n_vec++;
        if (state !== 2'd1 || armed !== 1'b0) begin
            n_err++; $display("FAIL arm_early: state=%0d armed=%0b, want 1/0", state, armed);
        end
        wait_ticks(1);
        n_vec++;
        if (state !== 2'd2 || armed !== 1'b1) begin
            n_err++; $display("FAIL arm_done: state=%0d armed=%0b, want 2/1", state, armed);
        end
        pulse_disarm();
        n_vec++;
        if (state !== 2'd0 || armed !== 1'b0) begin
            n_err++; $display("FAIL disarm: state=%0d armed=%0b, want 0/0", state, armed);
        end
        send_cmd('0);
        pulse_arm();
        send_cmd(pack4(0, 0, 5, 0));
        n_vec++;
        if (state !== 2'd1) begin
            n_err++; $display("FAIL arm_abort_latency: state=%0d, want 1", state);
        end
        step();
        n_vec++;
        if (state !== 2'd0) begin
            n_err++; $display("FAIL arm_abort: state=%0d, want 0", state);
        end
        send_cmd('0);
    endtask

    task automatic test_ramp();
        arm_up();
        send_cmd(pack4(20, 1023, 0, 0));
        wait_ticks(1);
        n_vec++;
        if (control_0 !== 10'd8 || control_1 !== 10'd8) begin
            n_err++; $display("FAIL ramp_tick1: l0=%0d l1=%0d, want 8/8", control_0, control_1);
        end
        wait_ticks(2);
        n_vec++;
        if (control_0 !== 10'd20 || control_1 !== 10'd24) begin
            n_err++; $display("FAIL ramp_tick3: l0=%0d l1=%0d, want 20/24", control_0, control_1);
        end
        for (int k = 4; k <= 126; k++) begin
            send_cmd(pack4(20, 1023, 0, 0));
            wait_ticks(1);
            if (k == 124) begin
                n_vec++;
                if (control_1 !== 10'd992) begin
                    n_err++; $display("FAIL ramp_tick124: l1=%0d, want 992", control_1);
                end
            end
            if (k == 125) begin
                n_vec++;
                if (control_1 !== 10'd1000) begin
                    n_err++; $display("FAIL ramp_tick125: l1=%0d, want 1000", control_1);
                end
            end
        end
        n_vec++;
        if (control_0 !== 10'd20 || control_1 !== 10'd1000 || state !== 2'd2) begin
            n_err++;
            $display("FAIL ramp_hold: l0=%0d l1=%0d state=%0d, want 20/1000/2", control_0, control_1, state);
        end
        send_cmd(pack4(20, 995, 0, 0));
        wait_ticks(1);
        n_vec++;
        if (control_1 !== 10'd995) begin
            n_err++; $display("FAIL ramp_small_step: l1=%0d, want 995", control_1);
        end
    endtask

    task automatic test_reset_midramp();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({control_0, control_1, control_2, control_3} !== '0 || state !== 2'd0 ||
            armed !== 1'b0 || frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midramp: ctrl=%0d/%0d/%0d/%0d state=%0d armed=%0b, want all 0",
                     control_0, control_1, control_2, control_3, state, armed);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_failsafe();
        arm_up();
        send_cmd(pack4(16, 16, 0, 0));
        wait_ticks(2);
        n_vec++;
        if (control_0 !== 10'd16 || control_1 !== 10'd16 || state !== 2'd2) begin
            n_err++; $display("FAIL fs_setup: l0=%0d l1=%0d state=%0d, want 16/16/2", control_0, control_1, state);
        end
        wait_ticks(1);
        n_vec++;
        if (state !== 2'd2) begin
            n_err++; $display("FAIL fs_tick3: state=%0d, want 2", state);
        end
        wait_ticks(1);
        n_vec++;
        if (state !== 2'd3 || armed !== 1'b0 || control_0 !== 10'd8 || control_1 !== 10'd8) begin
            n_err++;
            $display("FAIL fs_enter: state=%0d armed=%0b l0=%0d l1=%0d, want 3/0/8/8", state, armed, control_0, control_1);
        end
        send_cmd(pack4(500, 500, 500, 500));
        n_vec++;
        if (state !== 2'd3) begin
            n_err++; $display("FAIL fs_cmd_ignored: state=%0d, want 3", state);
        end
        wait_ticks(1);
        n_vec++;
        if (control_0 !== 10'd0 || control_1 !== 10'd0 || state !== 2'd3) begin
            n_err++; $display("FAIL fs_zero: l0=%0d l1=%0d state=%0d, want 0/0/3", control_0, control_1, state);
        end
        step();
        n_vec++;
        if (state !== 2'd0) begin
            n_err++; $display("FAIL fs_exit: state=%0d, want 0", state);
        end
    endtask

    task automatic test_simultaneous();
        arm_up();
        send_cmd(pack4(100, 0, 0, 40));
        wait_ticks(3);
        n_vec++;
        if (control_0 !== 10'd24 || control_3 !== 10'd24 || state !== 2'd2) begin
            n_err++; $display("FAIL sim_setup: l0=%0d l3=%0d state=%0d, want 24/24/2", control_0, control_3, state);
        end
        to_tick_edge();
        pulse_disarm();
        n_vec++;
        if (state !== 2'd0 || armed !== 1'b0 || control_0 !== 10'd0 || control_3 !== 10'd0) begin
            n_err++;
            $display("FAIL sim_disarm: state=%0d armed=%0b l0=%0d l3=%0d, want 0/0/0/0", state, armed, control_0, control_3);
        end
        arm_up();
        send_cmd(pack4(40, 0, 0, 0));
        wait_ticks(1);
        to_tick_edge();
        send_cmd('0);
        n_vec++;
        if (control_0 !== 10'd16) begin
            n_err++; $display("FAIL sim_cmd_tick_old_target: l0=%0d, want 16", control_0);
        end
        wait_ticks(1);
        n_vec++;
        if (control_0 !== 10'd8) begin
            n_err++; $display("FAIL sim_cmd_tick_new_target: l0=%0d, want 8", control_0);
        end
        wait_ticks(2);
        n_vec++;
        if (state !== 2'd2) begin
            n_err++; $display("FAIL sim_timeout_cleared: state=%0d, want 2", state);
        end
        wait_ticks(1);
        n_vec++;
        if (state !== 2'd3) begin
            n_err++; $display("FAIL sim_timeout_trip: state=%0d, want 3", state);
        end
        step();
    endtask

    task automatic test_random();
        int cv_rate;
        int shown = 0;
        for (int blk = 0; blk < 8; blk++) begin
            cv_rate = (blk % 2 == 0) ? 4 : 60;
            for (int c = 0; c < 500; c++) begin
                cmd_valid  = ($urandom_range(0, cv_rate - 1) == 0);
                arm_req    = ($urandom_range(0, 9) == 0);
                disarm_req = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 2) == 0) throttle_in = '0;
                else begin
                    for (int i = 0; i < 4; i++) begin
                        case ($urandom_range(0, 3))
                            0: throttle_in[10*i +: 10] = '0;
                            1: throttle_in[10*i +: 10] = 10'($urandom_range(0, 40));
                            2: throttle_in[10*i +: 10] = 10'($urandom_range(980, 1023));
                            default: throttle_in[10*i +: 10] = 10'($urandom_range(0, 1023));
                        endcase
                    end
                end
                step();
                n_vec++;
                if (state !== 2'(m_state) || armed !== (m_state == 2) || frame_tick !== (m_fcnt == FC - 1) ||
                    control_0 !== 10'(m_out[0]) || control_1 !== 10'(m_out[1]) ||
                    control_2 !== 10'(m_out[2]) || control_3 !== 10'(m_out[3])) begin
                    n_err++;
                    if (shown < 10) begin
                        shown++;
                        $display("FAIL random t=%0t: got st=%0d arm=%0b tk=%0b c=%0d/%0d/%0d/%0d want st=%0d c=%0d/%0d/%0d/%0d",
                                 $time, state, armed, frame_tick, control_0, control_1, control_2, control_3,
                                 m_state, m_out[0], m_out[1], m_out[2], m_out[3]);
                    end
                end
            end
        end
        cmd_valid = 1'b0; arm_req = 1'b0; disarm_req = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_arm();
        test_ramp();
        test_reset_midramp();
        test_failsafe();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/motor_arm_ramp.md
# motor_arm_ramp

Upstream command stage for the four motor PWM generators. Latches per-motor 10-bit throttle commands, gates them through an arming state machine with a zero-throttle hold, and slew-limits each output once per PWM frame. On command loss it ramps all motors to zero and disarms. Each `control_N` output drives the 10-bit `control` input of one PWM generator, where 0 gives a 1 ms pulse and 1000 gives a 2 ms pulse.

## Interface
- `FRAME_CYCLES`, default 1000000: clk cycles per update frame (50 MHz / 50 Hz).
- `RAMP_STEP`, default 8: maximum change of any output per frame.
- `MAX_CMD`, default 1000: clamp ceiling for latched targets (2 ms pulse).
- `ARM_FRAMES`, default 50: frames of zero throttle required before armed.
- `TIMEOUT_FRAMES`, default 25: frames without `cmd_valid` before failsafe.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: single-cycle strobe that latches `throttle_in`.
- `throttle_in` in 40: four 10-bit commands; motor N occupies bits [10N+9:10N].
- `arm_req` in 1: level or pulse; sampled every cycle.
- `disarm_req` in 1: level or pulse; sampled every cycle.
- `control_0`..`control_3` out 10 each: registered motor commands.
- `armed` out 1: high only in ARMED.
- `state` out 2: encoded FSM state.
- `frame_tick` out 1: one-cycle frame strobe, exposed for debug and verification.

## Operation
- **Target latch.** Target latch on `cmd_valid` happens in every state. Each lane is clamped to `MAX_CMD`, so 1023 becomes 1000.
- **Frame timer.** Counts 0..`FRAME_CYCLES`-1 and wraps. `frame_tick` is asserted when the count equals `FRAME_CYCLES`-1. The frame is not phase-locked to the PWM period.
- **Timeout counter.** Increments on `frame_tick` and saturates at `TIMEOUT_FRAMES`. It is cleared by `cmd_valid`. Clear wins when both occur in the same cycle.
- **DISARMED (00).** Outputs are 0. `arm_req` with all four targets equal to 0 moves to ARMING and clears the arm-frame counter.
- **ARMING (01).** Outputs are 0.
  - Any target ≠ 0 or `disarm_req` moves to DISARMED.
  - The arm counter increments per `frame_tick`.
  - When the counter reaches `ARM_FRAMES`, move to ARMED.
- **ARMED (10).** On each `frame_tick`, each output moves toward its target by at most `RAMP_STEP` and never overshoots. If |target − out| ≤ `RAMP_STEP`, then out = target.
  - `disarm_req` moves to DISARMED with outputs zeroed on the next cycle.
  - Timeout count equal to `TIMEOUT_FRAMES` moves to FAILSAFE.
- **FAILSAFE (11).** Effective targets are forced to 0, and outputs ramp down by `RAMP_STEP` per tick.
  - When all outputs are 0, move to DISARMED.
  - `cmd_valid` updates the latched targets but does not leave FAILSAFE.
  - `disarm_req` moves to DISARMED immediately.
- **Priority.** `disarm_req` beats timeout, which beats normal ramping. `arm_req` is ignored outside DISARMED.
- **Arithmetic.** Ramp arithmetic uses 11-bit signed differences. Outputs never leave the range 0..`MAX_CMD`.

## Timing
- **Reset.** `rst_n` low asynchronously forces:
  - all outputs 0, `armed`=0, `state`=DISARMED, `frame_tick`=0;
  - all counters and targets to 0.
  A reset mid-ramp behaves identically.
- **Latch latency.** `cmd_valid` at cycle t makes the target visible at t+1. A `frame_tick` in the same cycle t ramps toward the old target.
- **Output update.** Outputs change only in the cycle after `frame_tick`, or the cycle after a disarm.
- **`armed` timing.** `armed` and `state` are registered and update together with the transition. `armed` rises exactly `ARM_FRAMES` ticks after the ARMING entry.
- **Ramp duration.** A full-scale ramp from 0 to 1000 with step 8 takes 125 frames (2.5 s).

## Structure
- **Package `motor_pkg`.** Holds the state enum (DISARMED=0, ARMING=1, ARMED=2, FAILSAFE=3), `CMD_W`=10, `NUM_MOTORS`=4, and the default `MAX_CMD`.
- **Sub-module `frame_timer`.** Parameter `FRAME_CYCLES`; ports `clk`, `rst_n`, `frame_tick`. Reusable by other frame-rate logic.
- **Per-lane logic.** The clamp and slew logic is a generate loop over 4 lanes, not a separate module.

## Test plan
All scenarios use `FRAME_CYCLES`=10, `ARM_FRAMES`=3, `TIMEOUT_FRAMES`=4, `RAMP_STEP`=8.
1. **Reset.** Assert `rst_n`=0 mid-frame → all outputs 0, `state`=0, `armed`=0 within the same cycle, without a clock edge.
2. **Arm sequence.** `cmd_valid` with all lanes 0, then `arm_req` → ARMING. After 3 ticks → `armed`=1. Repeat with lane 2 = 5 during ARMING → returns to DISARMED.
3. **Ramp.**
   - In ARMED, command lane 0 = 20, lane 1 = 1023. After tick 1: lane 0 = 8, lane 1 = 8. After tick 3: lane 0 = 20 and holds.
   - Lane 1 saturates at 1000 after 125 ticks.
   - Then command lane 1 = 995 → lane 1 reaches 995 in one tick (step 5).
4. **Failsafe.** Stop `cmd_valid` with outputs at 16 → FAILSAFE at the 4th tick. Outputs go 8 then 0, then DISARMED. A `cmd_valid` issued during FAILSAFE does not restore ARMED.
5. **Simultaneous events.**
   - `disarm_req` coincident with `frame_tick` and a timeout → DISARMED, outputs 0 next cycle.
   - `cmd_valid` coincident with `frame_tick` → ramp uses the previous target, and the timeout counter reads 0.
